// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS PC sequencer: PC source select,
// run/halt FSM encoding and the default reset/trap vectors.
package mips_pkg;

   typedef enum logic [1:0] {
      PC_SEQ = 2'd0,
      PC_BR  = 2'd1,
      PC_J   = 2'd2,
      PC_JR  = 2'd3
   } pc_src_t;

   localparam logic [1:0] SEQ_IDLE   = 2'd0;
   localparam logic [1:0] SEQ_RUN    = 2'd1;
   localparam logic [1:0] SEQ_HALTED = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = SEQ_IDLE,
      ST_RUN    = SEQ_RUN,
      ST_HALTED = SEQ_HALTED
   } seq_state_t;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0080;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection and branch/jump/jr target arithmetic (all adds wrap mod 2^32).
// PC_TRAP_EN: a misaligned jr target redirects to TRAP_VECTOR and raises jr_trap.
module pc_next_mux
   import mips_pkg::*;
#(
   parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
   input  logic [31:0] pc,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic [31:0] pc_plus4,
   output logic [31:0] pc_next,
   output pc_src_t     pc_src,
   output logic        jr_trap
);

   logic [31:0] br_target;
   logic [31:0] j_target;
   logic [31:0] jr_dest;

`ifdef PC_TRAP_EN
   logic jr_misaligned;
   assign jr_misaligned = |jr_target[1:0];
   assign jr_dest       = jr_misaligned ? TRAP_VECTOR : jr_target;
   assign jr_trap       = jr & jr_misaligned;
`else
   // Low target bits are dropped so jr always lands word-aligned.
   logic unused_bits;
   assign unused_bits = ^{jr_target[1:0], TRAP_VECTOR};
   assign jr_dest     = {jr_target[31:2], 2'b00};
   assign jr_trap     = 1'b0;
`endif

   assign pc_plus4  = pc + 32'd4;
   assign br_target = pc_plus4 + (branch_offset << 2);
   assign j_target  = {pc_plus4[31:28], jump_target, 2'b00};

   always_comb begin
      pc_src = PC_SEQ;
      if (jr)                pc_src = PC_JR;
      else if (jump)         pc_src = PC_J;
      else if (branch_taken) pc_src = PC_BR;
   end

   always_comb begin
      pc_next = pc_plus4;
      case (pc_src)
         PC_BR:   pc_next = br_target;
         PC_J:    pc_next = j_target;
         PC_JR:   pc_next = jr_dest;
         default: pc_next = pc_plus4;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: PC register plus IDLE/RUN/HALTED fetch FSM.
// Optional PC_TRAP_EN: misaligned jr loads TRAP_VECTOR and pulses trap for one cycle.
module pc_sequencer
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        halt,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_valid,
   output logic [1:0]  seq_state,
   output logic        trap
);

   seq_state_t  state_q, state_d;
   logic [31:0] pc_q;
   logic [31:0] pc_next;
   pc_src_t     pc_src;
   logic        jr_trap;
   logic        advance;

   pc_next_mux #(
      .TRAP_VECTOR (TRAP_VECTOR)
   ) u_next (
      .pc            (pc_q),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_target   (jump_target),
      .jr            (jr),
      .jr_target     (jr_target),
      .pc_plus4      (pc_plus4),
      .pc_next       (pc_next),
      .pc_src        (pc_src),
      .jr_trap       (jr_trap)
   );

   // halt wins over run; the unused encoding falls back to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (run && !halt) state_d = ST_RUN;
         ST_RUN:    if (halt)         state_d = ST_HALTED;
         ST_HALTED: if (run && !halt) state_d = ST_RUN;
         default:                     state_d = ST_IDLE;
      endcase
   end

   assign advance = (state_q == ST_RUN) && !stall && !halt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_VECTOR;
      end else begin
         state_q <= state_d;
         if (advance) pc_q <= pc_next;
      end
   end

`ifdef PC_TRAP_EN
   logic trap_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) trap_q <= 1'b0;
      else        trap_q <= advance && jr_trap;
   end
   assign trap = trap_q;
`else
   logic unused_trap;
   assign unused_trap = ^{jr_trap, pc_src};
   assign trap        = 1'b0;
`endif

   assign pc          = pc_q;
   assign fetch_valid = (state_q == ST_RUN) && !stall;
   assign seq_state   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer with an expected-PC scoreboard queue.
// Expected values follow PC_TRAP_EN when the bench is built with that macro.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        run, halt, stall, branch_taken, jump, jr;
   logic [31:0] branch_offset, jr_target;
   logic [25:0] jump_target;
   logic [31:0] pc, pc_plus4;
   logic        fetch_valid, trap;
   logic [1:0]  seq_state;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic        run, halt, stall, br;
      logic [31:0] off;
      logic        j;
      logic [25:0] jt;
      logic        jr;
      logic [31:0] jrt;
      logic        exp_fv;
      logic [31:0] exp_pc;
      logic [1:0]  exp_st;
      logic        exp_trap;
   } vec_t;

   vec_t vecs[$];

   pc_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .run           (run),
      .halt          (halt),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_target   (jump_target),
      .jr            (jr),
      .jr_target     (jr_target),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .fetch_valid   (fetch_valid),
      .seq_state     (seq_state),
      .trap          (trap)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic r, input logic h, input logic s, input logic b,
                               input logic [31:0] o, input logic j, input logic [25:0] jt,
                               input logic jrr, input logic [31:0] jrt, input logic fv,
                               input logic [31:0] p, input logic [1:0] st, input logic tr);
      vec_t v;
      v.run = r; v.halt = h; v.stall = s; v.br = b; v.off = o; v.j = j; v.jt = jt;
      v.jr = jrr; v.jrt = jrt; v.exp_fv = fv; v.exp_pc = p; v.exp_st = st; v.exp_trap = tr;
      return v;
   endfunction

   // Drive one cycle of inputs, check comb fetch_valid, then compare after the edge.
   task automatic apply(input int idx, input vec_t v);
      logic [31:0] e_pc;
      run = v.run; halt = v.halt; stall = v.stall; branch_taken = v.br;
      branch_offset = v.off; jump = v.j; jump_target = v.jt; jr = v.jr; jr_target = v.jrt;
      #1;
      check($sformatf("v%0d fetch_valid", idx), {31'd0, fetch_valid}, {31'd0, v.exp_fv});
      exp_q.push_back(v.exp_pc);
      @(posedge clk);
      #1;
      e_pc = exp_q.pop_front();
      check($sformatf("v%0d pc", idx), pc, e_pc);
      check($sformatf("v%0d pc_plus4", idx), pc_plus4, e_pc + 32'd4);
      check($sformatf("v%0d seq_state", idx), {30'd0, seq_state}, {30'd0, v.exp_st});
      check($sformatf("v%0d trap", idx), {31'd0, trap}, {31'd0, v.exp_trap});
   endtask

   task automatic clear_inputs();
      run = 0; halt = 0; stall = 0; branch_taken = 0; jump = 0; jr = 0;
      branch_offset = '0; jump_target = '0; jr_target = '0;
   endtask

   initial begin
      logic [31:0] trap_pc, after_trap_pc;
      logic        trap_exp;
`ifdef PC_TRAP_EN
      trap_pc = 32'h80;  after_trap_pc = 32'h84;  trap_exp = 1'b1;
`else
      trap_pc = 32'h100; after_trap_pc = 32'h104; trap_exp = 1'b0;
`endif

      //         run h s br off            j jt      jr jrt            fv pc             st tr
      vecs.push_back(mk(0, 0,0,0, 32'h0,        0,26'h0,  0,32'h0,        0,32'h0,        2'd0,0));
      vecs.push_back(mk(1, 0,0,0, 32'h0,        0,26'h0,  0,32'h0,        0,32'h0,        2'd1,0));
      vecs.push_back(mk(1, 0,0,0, 32'h0,        0,26'h0,  0,32'h0,        1,32'h4,        2'd1,0));
      vecs.push_back(mk(1, 0,0,0, 32'h0,        0,26'h0,  0,32'h0,        1,32'h8,        2'd1,0));
      vecs.push_back(mk(1, 0,0,0, 32'h0,        0,26'h0,  0,32'h0,        1,32'hC,        2'd1,0));
      vecs.push_back(mk(0, 0,0,0, 32'h0,        0,26'h0,  1,32'h10,       1,32'h10,       2'd1,0));
      vecs.push_back(mk(0, 0,0,1, 32'hFFFF_FFFE,0,26'h0,  0,32'h0,        1,32'hC,        2'd1,0));
      vecs.push_back(mk(0, 0,0,0, 32'h0,        0,26'h0,  1,32'h1000_0000,1,32'h1000_0000,2'd1,0));
      vecs.push_back(mk(0, 0,0,1, 32'h5,        1,26'h40, 1,32'h200,      1,32'h200,      2'd1,0));
      vecs.push_back(mk(0, 0,0,0, 32'h0,        0,26'h0,  1,32'h1000_0000,1,32'h1000_0000,2'd1,0));
      vecs.push_back(mk(0, 0,0,1, 32'h5,        1,26'h40, 0,32'h0,        1,32'h1000_0100,2'd1,0));
      vecs.push_back(mk(0, 0,0,0, 32'h0,        0,26'h0,  1,32'h20,       1,32'h20,       2'd1,0));
      vecs.push_back(mk(0, 0,1,1, 32'h4,        0,26'h0,  0,32'h0,        0,32'h20,       2'd1,0));
      vecs.push_back(mk(0, 0,1,0, 32'h0,        1,26'h40, 0,32'h0,        0,32'h20,       2'd1,0));
      vecs.push_back(mk(0, 1,1,0, 32'h0,        0,26'h0,  0,32'h0,        0,32'h20,       2'd2,0));
      vecs.push_back(mk(0, 0,0,0, 32'h0,        1,26'h40, 0,32'h0,        0,32'h20,       2'd2,0));
      vecs.push_back(mk(1, 1,0,0, 32'h0,        0,26'h0,  0,32'h0,        0,32'h20,       2'd2,0));
      vecs.push_back(mk(1, 0,0,0, 32'h0,        0,26'h0,  0,32'h0,        0,32'h20,       2'd1,0));
      vecs.push_back(mk(0, 1,0,0, 32'h0,        0,26'h0,  0,32'h0,        1,32'h20,       2'd2,0));
      vecs.push_back(mk(1, 0,0,0, 32'h0,        0,26'h0,  0,32'h0,        0,32'h20,       2'd1,0));
      vecs.push_back(mk(0, 0,0,0, 32'h0,        0,26'h0,  1,32'hFFFF_FFFC,1,32'hFFFF_FFFC,2'd1,0));
      vecs.push_back(mk(0, 0,0,0, 32'h0,        0,26'h0,  0,32'h0,        1,32'h0,        2'd1,0));
      vecs.push_back(mk(0, 0,0,0, 32'h0,        0,26'h0,  1,32'h102,      1,trap_pc,      2'd1,trap_exp));
      vecs.push_back(mk(0, 0,0,0, 32'h0,        0,26'h0,  0,32'h0,        1,after_trap_pc,2'd1,0));

      // Reset state, checked while reset is still asserted.
      clear_inputs();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset pc", pc, 32'h0);
      check("reset pc_plus4", pc_plus4, 32'h4);
      check("reset seq_state", {30'd0, seq_state}, 32'd0);
      check("reset fetch_valid", {31'd0, fetch_valid}, 32'd0);
      check("reset trap", {31'd0, trap}, 32'd0);
      reset = 1'b1;

      foreach (vecs[i]) apply(i, vecs[i]);

      // Async reset between edges while running: takes effect without a clock.
      clear_inputs();
      run = 1'b1;
      reset = 1'b0;
      #1;
      check("async pc", pc, 32'h0);
      check("async seq_state", {30'd0, seq_state}, 32'd0);
      check("async fetch_valid", {31'd0, fetch_valid}, 32'd0);
      @(posedge clk);
      #1;
      check("held pc", pc, 32'h0);
      check("held seq_state", {30'd0, seq_state}, 32'd0);
      reset = 1'b1;

      // Resuming after reset needs run again.
      apply(100, mk(0,0,0,0,32'h0,0,26'h0,0,32'h0, 0,32'h0,2'd0,0));
      apply(101, mk(1,0,0,0,32'h0,0,26'h0,0,32'h0, 0,32'h0,2'd1,0));
      apply(102, mk(1,0,0,0,32'h0,0,26'h0,0,32'h0, 1,32'h4,2'd1,0));

      check("scoreboard drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
